alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit.sv | 169 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- pipelined execute-stage ALU for the Y86-64 core.
//
// Accepts an operand pair plus function code over a valid/ready handshake,
// computes ADD/SUB/AND/XOR and returns the result with the condition-code
// register over a second valid/ready handshake. Two register stages:
// S1 holds the captured operation, S2 holds the computed result.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   operation presented by decode
//   in_ready   unit can take an operation this cycle
//   ifun       0 ADD, 1 SUB, 2 AND, 3 XOR, 4..15 illegal
//   val_a      operand A (signed)
//   val_b      operand B (signed)
//   set_cc     operation updates the condition codes
//   out_valid  result valid
//   out_ready  consumer takes the result
//   val_e      result
//   cc         {ZF, SF, OF} condition-code register
//   err        presented result came from an illegal ifun
module alu_exec_unit #(
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              ifun,
  input  logic signed [WIDTH-1:0] val_a,
  input  logic signed [WIDTH-1:0] val_b,
  input  logic                    set_cc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] val_e,
  output logic [2:0]              cc,
  output logic                    err
);

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_XOR = 4'd3;

  localparam logic [2:0] CC_RESET = 3'b100;

  function automatic logic fn_legal(input logic [3:0] f);
    return (f <= FN_XOR);
  endfunction

  function automatic logic signed [WIDTH-1:0] alu_result(
    input logic [3:0]              f,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] r;
    case (f)
      FN_ADD:  r = b + a;
      FN_SUB:  r = b - a;
      FN_AND:  r = b & a;
      FN_XOR:  r = b ^ a;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Signed overflow: ADD overflows when equal-sign operands give a result of
  // the other sign; SUB (b - a) overflows when the operand signs differ and
  // the result sign departs from b. Logic ops never overflow.
  function automatic logic alu_ovf(
    input logic [3:0]              f,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic signed [WIDTH-1:0] e
  );
    logic o;
    case (f)
      FN_ADD:  o = (a[WIDTH-1] == b[WIDTH-1]) && (e[WIDTH-1] != a[WIDTH-1]);
      FN_SUB:  o = (a[WIDTH-1] != b[WIDTH-1]) && (e[WIDTH-1] != b[WIDTH-1]);
      default: o = 1'b0;
    endcase
    return o;
  endfunction

  function automatic logic [2:0] alu_flags(
    input logic [3:0]              f,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic signed [WIDTH-1:0] e
  );
    return {(e == '0), e[WIDTH-1], alu_ovf(f, a, b, e)};
  endfunction

  logic                    vld_p1;
  logic [3:0]              ifun_p1;
  logic signed [WIDTH-1:0] a_p1;
  logic signed [WIDTH-1:0] b_p1;
  logic                    set_cc_p1;

  logic                    vld_p2;
  logic signed [WIDTH-1:0] val_e_p2;
  logic                    err_p2;
  logic [2:0]              cc_q;

  logic                    s2_load;
  logic                    in_fire;
  logic                    legal_p1;
  logic signed [WIDTH-1:0] res_p1;
  logic [2:0]              flags_p1;

  // S2 moves whenever S1 has work and S2 is empty or being drained this edge,
  // so a consumed result and its successor swap without a bubble.
  assign s2_load  = vld_p1 && (!vld_p2 || out_ready);
  assign in_ready = !vld_p1 || s2_load;
  assign in_fire  = in_valid && in_ready;

  assign legal_p1 = fn_legal(ifun_p1);
  assign res_p1   = alu_result(ifun_p1, a_p1, b_p1);
  assign flags_p1 = alu_flags(ifun_p1, a_p1, b_p1, res_p1);

  // ---- stage boundary: decode -> S1 (operation capture) ----
  always_ff @(posedge clk) begin
    if (in_fire) begin
      ifun_p1   <= ifun;
      a_p1      <= val_a;
      b_p1      <= val_b;
      set_cc_p1 <= set_cc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (in_fire) begin
      vld_p1 <= 1'b1;
    end else if (s2_load) begin
      vld_p1 <= 1'b0;
    end
  end

  // ---- stage boundary: S1 -> S2 (result, error flag, condition codes) ----
  // The visible result fields are reset too, so a freshly reset unit
  // presents val_e = 0 / err = 0 rather than stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      val_e_p2 <= '0;
      err_p2   <= 1'b0;
      cc_q     <= CC_RESET;
    end else begin
      if (s2_load) begin
        vld_p2   <= 1'b1;
        val_e_p2 <= res_p1;
        err_p2   <= !legal_p1;
        if (set_cc_p1 && legal_p1) begin
          cc_q <= flags_p1;
        end
      end else if (out_ready) begin
        vld_p2 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p2;
  assign val_e     = val_e_p2;
  assign err       = err_p2;
  assign cc        = cc_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         ifun;
  logic signed [63:0] val_a;
  logic signed [63:0] val_b;
  logic               set_cc;
  logic               out_valid;
  logic               out_ready;
  logic signed [63:0] val_e;
  logic [2:0]         cc;
  logic               err;

  alu_exec_unit #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ifun      (ifun),
    .val_a     (val_a),
    .val_b     (val_b),
    .set_cc    (set_cc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .val_e     (val_e),
    .cc        (cc),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] e;
    logic        er;
    logic [2:0]  c;
  } exp_t;

  typedef struct {
    logic [3:0]  f;
    logic [63:0] a;
    logic [63:0] b;
    logic        sc;
    logic [63:0] e;
    logic        er;
    logic [2:0]  c;
  } vec_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   accepted = 0;

  logic        prev_stall = 1'b0;
  logic [63:0] prev_e;
  logic        prev_err;
  logic [2:0]  prev_cc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: pops the scoreboard on every output transfer and checks
  // that a stalled result holds still.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got val_e=%h expected no output", val_e);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          check("val_e", val_e, x.e);
          check("err", {63'd0, err}, {63'd0, x.er});
          check("cc", {61'd0, cc}, {61'd0, x.c});
          pop_cyc.push_back(cyc);
        end
      end
      if (out_valid && !out_ready) begin
        if (prev_stall) begin
          check("stall_val_e", val_e, prev_e);
          check("stall_err", {63'd0, err}, {63'd0, prev_err});
          check("stall_cc", {61'd0, cc}, {61'd0, prev_cc});
        end
        prev_stall = 1'b1;
        prev_e     = val_e;
        prev_err   = err;
        prev_cc    = cc;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Presents one operation, holds it until accepted (bounded), and records
  // the expected result at the moment of acceptance.
  task automatic send(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                      input logic sc, input logic [63:0] e, input logic er,
                      input logic [2:0] c, output bit waited);
    int   budget;
    exp_t x;
    budget   = 0;
    waited   = 0;
    ifun     = f;
    val_a    = a;
    val_b    = b;
    set_cc   = sc;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited = 1;
      budget++;
      if (budget > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", budget);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    x.e  = e;
    x.er = er;
    x.c  = c;
    exp_q.push_back(x);
    accepted++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  vec_t tbl[8];
  bit   w;
  int   waits;
  int   base;

  initial begin
    tbl[0] = '{4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 3'b011};
    tbl[1] = '{4'd1, 64'd5, 64'd5, 1'b1, 64'd0, 1'b0, 3'b100};
    tbl[2] = '{4'd2, 64'hF0, 64'h0F, 1'b0, 64'd0, 1'b0, 3'b100};
    tbl[3] = '{4'd1, 64'd3, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3'b010};
    tbl[4] = '{4'd7, 64'd3, 64'd3, 1'b1, 64'd0, 1'b1, 3'b010};
    tbl[5] = '{4'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'd0, 1'b0, 3'b101};
    tbl[6] = '{4'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001};
    tbl[7] = '{4'd3, 64'hFF, 64'hFF, 1'b1, 64'd0, 1'b0, 3'b100};

    rst       = 1'b1;
    in_valid  = 1'b0;
    ifun      = 4'd0;
    val_a     = '0;
    val_b     = '0;
    set_cc    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_val_e", val_e, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_cc", {61'd0, cc}, 64'd4);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven operations; the first one also checks latency.
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].sc, tbl[i].e, tbl[i].er, tbl[i].c, w);
      if (i == 0) begin
        @(negedge clk);
        check("lat_after_accept", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        check("lat_one_edge_later", {63'd0, out_valid}, 64'd1);
      end
    end
    drain();

    // Back-to-back XOR stream.
    base  = pop_cyc.size();
    waits = 0;
    for (int i = 0; i < 6; i++) begin
      send(4'd3, 64'(i), 64'hFF, 1'b1, 64'hFF ^ 64'(i), 1'b0, 3'b000, w);
      waits += int'(w);
    end
    drain();
    check("stream_no_stall", 64'(waits), 64'd0);
    if (pop_cyc.size() >= base + 6)
      check("stream_consecutive", 64'(pop_cyc[base+5] - pop_cyc[base]), 64'd5);
    else
      check("stream_pop_count", 64'(pop_cyc.size() - base), 64'd6);

    // Backpressure: two accepts fill the pipe, the third waits.
    out_ready = 1'b0;
    base      = accepted;
    fork
      begin
        send(4'd0, 64'd10, 64'd20, 1'b0, 64'd30, 1'b0, 3'b000, w);
        send(4'd1, 64'd1, 64'd10, 1'b0, 64'd9, 1'b0, 3'b000, w);
        send(4'd2, 64'd6, 64'd3, 1'b0, 64'd2, 1'b0, 3'b000, w);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        check("bp_accepts", 64'(accepted - base), 64'd2);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operations in flight.
    out_ready = 1'b0;
    send(4'd0, 64'd1, 64'd1, 1'b1, 64'd2, 1'b0, 3'b000, w);
    send(4'd1, 64'd1, 64'd1, 1'b1, 64'd0, 1'b0, 3'b100, w);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_cc", {61'd0, cc}, 64'd4);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    send(4'd0, 64'd2, 64'd3, 1'b1, 64'd5, 1'b0, 3'b000, w);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("final_idle", {63'd0, out_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
